// File: rtl/apb_master_arb_if.sv
// ---------------------------------------------------------------------------
// apb_master_arb_if
// Bundles the requester-side handshake and the APB bus of apb_master_arb.
//
// Requester side : req_valid, req_write, req_addr, req_wdata (to master)
//                  req_ack, req_done, req_rdata, req_err       (from master)
// APB side       : PSEL, PENABLE, PWRITE, PADDR, PWDATA        (from master)
//                  PRDATA, PREADY, PSLVERR                     (to master)
//
// Requester i owns slice [i*AWIDTH +: AWIDTH] of req_addr and
// [i*DWIDTH +: DWIDTH] of req_wdata.
//
// Modports:
//   master : the arbiter/APB master view
//   slave  : the environment view (requesters plus APB slave)
// ---------------------------------------------------------------------------
interface apb_master_arb_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
);

  // Requester side
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*AWIDTH-1:0] req_addr;
  logic [2*DWIDTH-1:0] req_wdata;
  logic [1:0]          req_ack;
  logic [1:0]          req_done;
  logic [DWIDTH-1:0]   req_rdata;
  logic                req_err;

  // APB side
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [AWIDTH-1:0]   PADDR;
  logic [DWIDTH-1:0]   PWDATA;
  logic [DWIDTH-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output req_ack, req_done, req_rdata, req_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  req_ack, req_done, req_rdata, req_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master_arb.sv
// ---------------------------------------------------------------------------
// apb_master_arb
// Two-requester APB master. Grants one requester at a time using round-robin
// arbitration, runs the IDLE/SETUP/ACCESS sequence on the APB bus, honours
// PREADY wait states and returns read data / slave error to the requester.
//
// Ports:
//   PCLK     : bus clock, all logic on the rising edge
//   PRESETn  : synchronous active-low reset
//   bus      : apb_master_arb_if.master (requester handshake + APB bus)
//
// Parameters:
//   AWIDTH   : APB address width
//   DWIDTH   : APB data width
//   TIMEOUT  : ACCESS cycles with PREADY low before the transfer is
//              abandoned (1..255); only used when APB_TIMEOUT_EN is defined
//
// Configuration macro:
//   APB_TIMEOUT_EN : when defined, a stalled ACCESS phase is terminated after
//                    TIMEOUT cycles and reported with req_err=1.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module apb_master_arb #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_master_arb_if.master  bus
);

  // Parameter sanity check at elaboration time.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("apb_master_arb: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q,   state_d;
  logic                last_q,    last_d;    // most recently granted requester
  logic                gnt_q,     gnt_d;     // requester owning the transfer
  logic                psel_q,    psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q,  pwrite_d;
  logic [AWIDTH-1:0]   paddr_q,   paddr_d;
  logic [DWIDTH-1:0]   pwdata_q,  pwdata_d;
  logic [1:0]          ack_q,     ack_d;
  logic [1:0]          done_q,    done_d;
  logic [DWIDTH-1:0]   rdata_q,   rdata_d;
  logic                err_q,     err_d;
  logic                gnt_sel;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]          cnt_q,     cnt_d;     // ACCESS cycles seen with PREADY low
`endif

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // the block leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    ack_d     = 2'b00;
    done_d    = 2'b00;
    err_d     = 1'b0;
    gnt_sel   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          // Contention goes to the requester that did not win last time;
          // a lone request is granted directly.
          gnt_sel   = (&bus.req_valid) ? ~last_q : bus.req_valid[1];
          gnt_d     = gnt_sel;
          last_d    = gnt_sel;
          pwrite_d  = bus.req_write[gnt_sel];
          paddr_d   = gnt_sel ? bus.req_addr[AWIDTH +: AWIDTH]
                              : bus.req_addr[0 +: AWIDTH];
          pwdata_d  = gnt_sel ? bus.req_wdata[DWIDTH +: DWIDTH]
                              : bus.req_wdata[0 +: DWIDTH];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          ack_d     = gnt_sel ? 2'b10 : 2'b01;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = 8'd0;
`endif
      end

      ST_ACCESS: begin
        // PREADY wins over a timeout expiring in the same cycle.
        if (bus.PREADY) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q ? 2'b10 : 2'b01;
          err_d     = bus.PSLVERR;
          if (!pwrite_q) begin
            rdata_d = bus.PRDATA;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q ? 2'b10 : 2'b01;
          err_d     = 1'b1;
        end else begin
          cnt_d     = cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    // NOTE: reset is sampled on the clock edge (synchronous); all state uses
    // non-blocking assignments so every flop sees pre-edge values.
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;      // requester 0 wins the first contention
      gnt_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.req_ack   = ack_q;
  assign bus.req_done  = done_q;
  assign bus.req_rdata = rdata_q;
  assign bus.req_err   = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arb
// Self-checking bench for apb_master_arb. A transaction-level model keeps the
// round-robin winner and the last read data; each transfer's expected bus
// timeline (SETUP, k wait states, completion) is derived from that model.
// Define APB_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
// ---------------------------------------------------------------------------
module tb_apb_master_arb;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 4;

  logic pclk;
  logic presetn;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit            last_m;
  logic [DW-1:0] rdata_m;

  apb_master_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  apb_master_arb #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK    (pclk),
    .PRESETn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: on contention the requester other than the last winner.
  function automatic bit pick(input logic [1:0] mask);
    if (mask == 2'b11) return !last_m;
    return mask[1];
  endfunction

  task automatic slave_noise();
    bus.PREADY  = 1'($urandom);
    bus.PRDATA  = DW'($urandom);
    bus.PSLVERR = 1'($urandom);
  endtask

  task automatic req_noise();
    bus.req_write = 2'($urandom);
    bus.req_addr  = (2*AW)'($urandom);
    bus.req_wdata = (2*DW)'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"},    32'(bus.PSEL),      0);
    check({tag, "_penable"}, 32'(bus.PENABLE),   0);
    check({tag, "_pwrite"},  32'(bus.PWRITE),    0);
    check({tag, "_paddr"},   32'(bus.PADDR),     0);
    check({tag, "_pwdata"},  32'(bus.PWDATA),    0);
    check({tag, "_ack"},     32'(bus.req_ack),   0);
    check({tag, "_done"},    32'(bus.req_done),  0);
    check({tag, "_rdata"},   32'(bus.req_rdata), 0);
    check({tag, "_err"},     32'(bus.req_err),   0);
  endtask

  // Call at a negedge with the DUT idle; returns at the negedge of the
  // completion cycle (DUT idle again).
  task automatic do_xfer(input logic [1:0] mask, input int k, input bit stuck,
                         input logic [1:0] wr, input logic [2*AW-1:0] addr,
                         input logic [2*DW-1:0] wd, input logic [DW-1:0] prd,
                         input logic slverr, input logic [1:0] hold);
    bit            g;
    int            n_acc;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [31:0]   e_ack;

    g      = pick(mask);
    last_m = g;
    e_wr   = wr[g];
    e_addr = g ? addr[AW +: AW] : addr[0 +: AW];
    e_wd   = g ? wd[DW +: DW]   : wd[0 +: DW];
    e_ack  = g ? 32'd2 : 32'd1;
    n_acc  = stuck ? TO : k + 1;

    bus.req_valid = mask;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    slave_noise();

    @(negedge pclk);  // SETUP
    check("setup_psel",    32'(bus.PSEL),     1);
    check("setup_penable", 32'(bus.PENABLE),  0);
    check("setup_ack",     32'(bus.req_ack),  e_ack);
    check("setup_done",    32'(bus.req_done), 0);
    check("setup_paddr",   32'(bus.PADDR),    32'(e_addr));
    check("setup_pwrite",  32'(bus.PWRITE),   32'(e_wr));
    check("setup_pwdata",  32'(bus.PWDATA),   32'(e_wd));

    // Requester inputs are free to change once acknowledged.
    bus.req_valid = hold;
    req_noise();
    slave_noise();

    for (int c = 0; c < n_acc; c++) begin
      @(negedge pclk);  // ACCESS
      check("acc_psel",    32'(bus.PSEL),     1);
      check("acc_penable", 32'(bus.PENABLE),  1);
      check("acc_paddr",   32'(bus.PADDR),    32'(e_addr));
      check("acc_pwrite",  32'(bus.PWRITE),   32'(e_wr));
      check("acc_pwdata",  32'(bus.PWDATA),   32'(e_wd));
      check("acc_ackdone", 32'({bus.req_ack, bus.req_done}), 0);
      if (!stuck && c == k) begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = prd;
        bus.PSLVERR = slverr;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = DW'($urandom);
        bus.PSLVERR = 1'($urandom);
      end
    end

    @(negedge pclk);  // completion cycle
    if (!stuck && !e_wr) rdata_m = prd;
    check("done_done",    32'(bus.req_done),  e_ack);
    check("done_err",     32'(bus.req_err),   stuck ? 32'd1 : 32'(slverr));
    check("done_rdata",   32'(bus.req_rdata), 32'(rdata_m));
    check("done_psel",    32'(bus.PSEL),      0);
    check("done_penable", 32'(bus.PENABLE),   0);
    check("done_ack",     32'(bus.req_ack),   0);

    bus.req_valid = 2'b00;
    slave_noise();
  endtask

  task automatic idle(input int n);
    bus.req_valid = 2'b00;
    for (int c = 0; c < n; c++) begin
      slave_noise();
      @(negedge pclk);
      check("idle_psel",    32'(bus.PSEL),     0);
      check("idle_ackdone", 32'({bus.req_ack, bus.req_done}), 0);
    end
  endtask

  task automatic apply_reset();
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    last_m  = 1'b1;
    rdata_m = '0;
  endtask

  initial begin
    int acc_cycles;
    int done_seen;

    presetn       = 1'b0;
    bus.req_valid = 2'b11;  // reset must dominate a pending request
    bus.req_write = 2'b11;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = '1;
    bus.PSLVERR   = 1'b1;
    last_m        = 1'b1;
    rdata_m       = '0;

    // Reset state
    repeat (3) @(negedge pclk);
    check_all_zero("reset");
    presetn       = 1'b1;
    bus.req_valid = 2'b00;

    // Single write, no wait states: req0, addr 2, wdata 0xA5
    do_xfer(2'b01, 0, 1'b0, 2'b01, 8'h02, 16'h00A5, 8'h77, 1'b0, 2'b00);

    // Read with two wait states: req1, addr 5, PRDATA 0x3C
    do_xfer(2'b10, 2, 1'b0, 2'b00, 8'h50, 16'h0000, 8'h3C, 1'b0, 2'b00);

    // Continuous contention: alternating grants, one transfer per 3 cycles
    for (int i = 0; i < 4; i++) begin
      do_xfer(2'b11, 0, 1'b0, 2'($urandom), (2*AW)'($urandom),
              (2*DW)'($urandom), DW'($urandom), 1'b0, 2'b11);
    end

    // Slave error on a read: req0, addr 7
    do_xfer(2'b01, 0, 1'b0, 2'b00, 8'h07, 16'h0000, 8'hC3, 1'b1, 2'b00);

    // Request dropped before any clock edge saw it: nothing happens
    bus.req_valid = 2'b01;
    #2;
    bus.req_valid = 2'b00;
    @(negedge pclk);
    check("glitch_ack",  32'(bus.req_ack), 0);
    check("glitch_psel", 32'(bus.PSEL),    0);

    // Reset during ACCESS, with PREADY high at the reset edge
    bus.req_valid = 2'b10;
    last_m        = pick(2'b10);
    @(negedge pclk);
    bus.req_valid = 2'b00;
    bus.PREADY    = 1'b0;
    @(negedge pclk);
    check("mid_rst_in_access", 32'(bus.PENABLE), 1);
    presetn       = 1'b0;
    bus.PREADY    = 1'b1;
    @(negedge pclk);
    check_all_zero("mid_rst");
    presetn = 1'b1;
    last_m  = 1'b1;
    rdata_m = '0;
    // First contention after reset goes to requester 0
    do_xfer(2'b11, 1, 1'b0, 2'b00, 8'h9A, 16'h1234, 8'h5E, 1'b0, 2'b00);

    // Slave that never raises PREADY
`ifdef APB_TIMEOUT_EN
    do_xfer(2'b10, 0, 1'b1, 2'b00, 8'h30, 16'h0000, 8'h00, 1'b0, 2'b00);
    do_xfer(2'b01, 0, 1'b1, 2'b01, 8'h0B, 16'h00EE, 8'h00, 1'b0, 2'b00);
`else
    bus.req_valid = 2'b01;
    last_m        = pick(2'b01);
    @(negedge pclk);
    bus.req_valid = 2'b00;
    bus.PREADY    = 1'b0;
    acc_cycles    = 0;
    done_seen     = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge pclk);
      if (bus.PSEL && bus.PENABLE) acc_cycles++;
      if (bus.req_done != 2'b00)   done_seen++;
    end
    check("stuck_access_cycles", 32'(acc_cycles), 110);
    check("stuck_no_done",       32'(done_seen),  0);
    apply_reset();
    check("stuck_rst_psel", 32'(bus.PSEL), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      do_xfer(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b0,
              2'($urandom), (2*AW)'($urandom), (2*DW)'($urandom),
              DW'($urandom), 1'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master that arbitrates between requesters and drives one APB bus into the register-slave address decoder. It runs the IDLE/SETUP/ACCESS protocol, honours PREADY wait states, and returns read data and error status to the granted requester. Arbitration is round-robin, with one transfer in flight at a time.

## Interface
Parameters:
- AWIDTH, 4, APB address width.
- DWIDTH, 8, APB data width.
- TIMEOUT, 15, maximum ACCESS cycles with PREADY low. Used only when APB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- PCLK  in  1  bus clock; all logic on the rising edge.
- PRESETn  in  1  reset, synchronous and active-low.
- req_valid  in  2  per-requester transfer request, bit i = requester i.
- req_write  in  2  1 = write, 0 = read, per requester.
- req_addr  in  2*AWIDTH  addresses; requester i at [i*AWIDTH +: AWIDTH].
- req_wdata  in  2*DWIDTH  write data; requester i at [i*DWIDTH +: DWIDTH].
- req_ack  out  2  one-cycle pulse: request i accepted, and the requester may change its inputs.
- req_done  out  2  one-cycle pulse: transfer for requester i finished.
- req_rdata  out  DWIDTH  read data of the last completed read. Shared by both requesters.
- req_err  out  1  error status; valid only while a req_done bit is high.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  AWIDTH  APB address.
- PWDATA  out  DWIDTH  APB write data.
- PRDATA  in  DWIDTH  slave read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

## Operation
- All outputs are registered.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid:
  - grant per round-robin;
  - latch that requester's write, addr and wdata into PWRITE, PADDR and PWDATA;
  - go to SETUP.
- Round-robin:
  - the pointer `last` holds the most recently granted requester;
  - if both are valid, grant the requester other than `last`; if only one is valid, grant that one;
  - `last` updates on every grant.
- SETUP: PSEL=1, PENABLE=0, req_ack[g]=1 for exactly this cycle. Next state is always ACCESS.
- ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA are held stable.
  - PREADY=0: stay in ACCESS.
  - PREADY=1: go to IDLE.
- On leaving ACCESS with PREADY=1:
  - req_done[g]=1 and req_err=PSLVERR;
  - req_rdata is loaded with PRDATA if the transfer was a read, and is unchanged for a write;
  - PSEL and PENABLE return to 0.
- Requests are never queued. A requester holds its inputs stable from req_valid until req_ack; inputs after req_ack are ignored until the next IDLE.
- There is at least one IDLE cycle between transfers, so peak throughput is one transfer per 3 cycles.
- req_valid dropped before a grant: no transfer occurs; the request is not remembered.

## Timing
- Reset (PRESETn sampled low at a rising edge):
  - next state is IDLE;
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ack, req_done, req_rdata and req_err are all 0;
  - `last` = 1, so requester 0 wins the first contention.
- Reset mid-transfer (SETUP or ACCESS): abort immediately. No req_done is issued for the aborted transfer, and the bus is idle in the following cycle.
- Latency, with req_valid high and the FSM in IDLE at edge n:
  - edge n+1: SETUP, req_ack;
  - edge n+2: ACCESS;
  - first PREADY=1 sample at edge n+2+k: req_done high in the cycle after that edge. k=0 means no wait states.
- Both req_valid bits rising in the same cycle is resolved by `last` only. There is no fixed priority.
- req_done and req_ack are never high for both requesters at the same time.
- PRDATA and PSLVERR are sampled only in ACCESS with PREADY=1; they are ignored in every other state.

## Configuration
- Macro: APB_TIMEOUT_EN.
- Defined:
  - an 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0;
  - when the count reaches TIMEOUT with PREADY still 0, the transfer ends: go to IDLE, req_done[g]=1, req_err=1, req_rdata unchanged, PSEL and PENABLE drop;
  - PREADY=1 in the same cycle as the timeout is a normal completion and takes priority.
- Not defined: no counter. ACCESS waits for PREADY indefinitely, and TIMEOUT is unused.

## Test plan
- Single write, no wait states: req0 write, addr 2, wdata 0xA5, PREADY=1 → edge n+1 SETUP with PADDR=2 and req_ack=01; edge n+2 PENABLE=1; req_done=01 and req_err=0 in the next cycle.
- Read with wait states: req1 read, addr 5, PREADY low for 2 ACCESS cycles, PRDATA=0x3C → ACCESS lasts 3 cycles with PADDR stable; req_done=10 and req_rdata=0x3C.
- Contention: both requesters valid continuously after reset → grant order 0,1,0,1, with req_ack alternating 01/10 every 3 cycles.
- Slave error: req0 read, addr 7, PSLVERR=1 with PREADY=1 → req_done=01, req_err=1, req_rdata=PRDATA.
- Reset mid-ACCESS: PRESETn=0 for 1 cycle during ACCESS → next cycle all outputs 0, no req_done; a new request afterwards is granted to requester 0.
- APB_TIMEOUT_EN with TIMEOUT=4, PREADY stuck at 0 → req_done with req_err=1 after 4 ACCESS cycles; without the macro, ACCESS persists for more than 100 cycles.
